// File: rtl/fpu_sequencer_if.sv
// rtl/fpu_sequencer_if.sv - request/control bundle between the main FSM and the FPU sequencer
interface fpu_sequencer_if;
   logic       FPUStart;
   logic [1:0] FPUOp;
   logic       Special;
   logic       Flush;
   logic       Busy;
   logic       UnpackEn;
   logic       AlignEn;
   logic       ExecEn;
   logic       NormEn;
   logic       RoundEn;
   logic       DivInit;
   logic [4:0] IterCnt;
   logic [1:0] OpQ;
   logic       ResSel;
   logic       FPUW;
   logic       Done;

   modport master (
      output FPUStart, FPUOp, Special, Flush,
      input  Busy, UnpackEn, AlignEn, ExecEn, NormEn, RoundEn,
      input  DivInit, IterCnt, OpQ, ResSel, FPUW, Done
   );

   modport slave (
      input  FPUStart, FPUOp, Special, Flush,
      output Busy, UnpackEn, AlignEn, ExecEn, NormEn, RoundEn,
      output DivInit, IterCnt, OpQ, ResSel, FPUW, Done
   );
endinterface

// File: rtl/fpu_sequencer.sv
// rtl/fpu_sequencer.sv - control FSM stepping one FP op through unpack/align/exec/norm/round/writeback
module fpu_sequencer #(
   parameter int DIV_ITERS = 24
) (
   input  logic             clk,
   input  logic             reset,
   fpu_sequencer_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_ALIGN  = 3'd2,
      S_EXEC   = 3'd3,
      S_NORM   = 3'd4,
      S_ROUND  = 3'd5,
      S_WB     = 3'd6
   } state_t;

   localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

   state_t     r_state;
   state_t     w_next;
   logic [4:0] r_iter_cnt;
   logic [4:0] w_iter_next;
   logic [1:0] r_op_q;
   logic       r_res_sel;
   logic       w_accept;
   logic       w_is_div;

   assign w_accept    = (r_state == S_IDLE) && bus.FPUStart && !bus.Flush;
   assign w_is_div    = (r_op_q == 2'b11);
   assign bus.IterCnt = r_iter_cnt;
   assign bus.OpQ     = r_op_q;
   assign bus.ResSel  = r_res_sel;

   always_comb begin
      w_next       = S_IDLE;
      w_iter_next  = 5'd0;
      bus.Busy     = 1'b0;
      bus.UnpackEn = 1'b0;
      bus.AlignEn  = 1'b0;
      bus.ExecEn   = 1'b0;
      bus.NormEn   = 1'b0;
      bus.RoundEn  = 1'b0;
      bus.DivInit  = 1'b0;
      bus.FPUW     = 1'b0;
      bus.Done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_next = w_accept ? S_UNPACK : S_IDLE;
         end
         S_UNPACK: begin
            bus.Busy     = 1'b1;
            bus.UnpackEn = 1'b1;
            if (bus.Special)    w_next = S_WB;
            else if (r_op_q[1]) w_next = S_EXEC;
            else                w_next = S_ALIGN;
         end
         S_ALIGN: begin
            bus.Busy    = 1'b1;
            bus.AlignEn = 1'b1;
            w_next      = S_EXEC;
         end
         S_EXEC: begin
            bus.Busy   = 1'b1;
            bus.ExecEn = 1'b1;
            w_next     = S_NORM;
            // Divide loops here; the counter doubles as the iteration index for the datapath.
            if (w_is_div) begin
               bus.DivInit = (r_iter_cnt == 5'd0);
               if (r_iter_cnt != LAST_ITER) begin
                  w_next      = S_EXEC;
                  w_iter_next = r_iter_cnt + 5'd1;
               end
            end
         end
         S_NORM: begin
            bus.Busy   = 1'b1;
            bus.NormEn = 1'b1;
            w_next     = S_ROUND;
         end
         S_ROUND: begin
            bus.Busy    = 1'b1;
            bus.RoundEn = 1'b1;
            w_next      = S_WB;
         end
         S_WB: begin
            bus.Busy = 1'b1;
            bus.FPUW = !bus.Flush;
            bus.Done = !bus.Flush;
            w_next   = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
      if (bus.Flush && (r_state != S_IDLE)) begin
         w_next      = S_IDLE;
         w_iter_next = 5'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_iter_cnt <= 5'd0;
         r_op_q     <= 2'b00;
         r_res_sel  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_iter_cnt <= w_iter_next;
         if (w_accept) begin
            r_op_q    <= bus.FPUOp;
            r_res_sel <= 1'b0;
         end else if ((r_state == S_UNPACK) && bus.Special && !bus.Flush) begin
            r_res_sel <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fpu_sequencer.sv
// tb/tb_fpu_sequencer.sv - directed-vector bench for fpu_sequencer
module tb_fpu_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fpu_sequencer_if bus_if ();

   fpu_sequencer #(.DIV_ITERS(24)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // {Busy, UnpackEn, AlignEn, ExecEn, NormEn, RoundEn, DivInit, FPUW, Done}
   logic [8:0] obs;
   assign obs = {bus_if.Busy, bus_if.UnpackEn, bus_if.AlignEn, bus_if.ExecEn,
                 bus_if.NormEn, bus_if.RoundEn, bus_if.DivInit, bus_if.FPUW, bus_if.Done};

   localparam logic [8:0] V_IDLE = 9'b0_00000_000;
   localparam logic [8:0] V_UNP  = 9'b1_10000_000;
   localparam logic [8:0] V_ALN  = 9'b1_01000_000;
   localparam logic [8:0] V_EXE  = 9'b1_00100_000;
   localparam logic [8:0] V_DIVI = 9'b1_00100_100;
   localparam logic [8:0] V_NRM  = 9'b1_00010_000;
   localparam logic [8:0] V_RND  = 9'b1_00001_000;
   localparam logic [8:0] V_WB   = 9'b1_00000_011;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus_if.FPUStart = 1'b0;
      bus_if.FPUOp    = 2'b00;
      bus_if.Special  = 1'b0;
      bus_if.Flush    = 1'b0;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL reset_outputs: got %b want %b", obs, V_IDLE);
      end
      checks++;
      if ({bus_if.IterCnt, bus_if.OpQ, bus_if.ResSel} !== 8'd0) begin
         errors++;
         $display("FAIL reset_regs: got iter=%0d opq=%b ressel=%b want 0", bus_if.IterCnt, bus_if.OpQ, bus_if.ResSel);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_special;
      logic [8:0] exp;
      bus_if.FPUStart = 1'b1;
      bus_if.FPUOp    = 2'b10;
      for (int c = 0; c <= 3; c++) begin
         if (c > 0) tick();
         if (c == 1) begin bus_if.FPUStart = 1'b0; bus_if.Special = 1'b1; end
         if (c == 2) bus_if.Special = 1'b0;
         @(negedge clk);
         case (c)
            1:       exp = V_UNP;
            2:       exp = V_WB;
            default: exp = V_IDLE;
         endcase
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL special_c%0d: got %b want %b", c, obs, exp);
         end
         if (c >= 2) begin
            checks++;
            if (bus_if.ResSel !== 1'b1) begin
               errors++;
               $display("FAIL special_ressel_c%0d: got %b want 1", c, bus_if.ResSel);
            end
         end
      end
   endtask

   task automatic test_add;
      logic [8:0] exp;
      bus_if.FPUStart = 1'b1;
      bus_if.FPUOp    = 2'b00;
      for (int c = 0; c <= 7; c++) begin
         if (c > 0) tick();
         if (c == 1) bus_if.FPUStart = 1'b0;
         if (c == 2) bus_if.FPUOp = 2'b11;
         bus_if.Special = (c == 3);
         @(negedge clk);
         case (c)
            1:       exp = V_UNP;
            2:       exp = V_ALN;
            3:       exp = V_EXE;
            4:       exp = V_NRM;
            5:       exp = V_RND;
            6:       exp = V_WB;
            default: exp = V_IDLE;
         endcase
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL add_c%0d: got %b want %b", c, obs, exp);
         end
         if (c == 4) begin
            checks++;
            if (bus_if.OpQ !== 2'b00 || bus_if.ResSel !== 1'b0) begin
               errors++;
               $display("FAIL add_opq_ressel: got opq=%b ressel=%b want 00 0", bus_if.OpQ, bus_if.ResSel);
            end
         end
      end
   endtask

   task automatic test_div;
      logic [8:0] exp;
      logic [4:0] exp_it;
      bus_if.FPUStart = 1'b1;
      bus_if.FPUOp    = 2'b11;
      for (int c = 0; c <= 29; c++) begin
         if (c > 0) tick();
         if (c == 1) bus_if.FPUStart = 1'b0;
         @(negedge clk);
         if (c == 1)                exp = V_UNP;
         else if (c == 2)           exp = V_DIVI;
         else if (c >= 3 && c <= 25) exp = V_EXE;
         else if (c == 26)          exp = V_NRM;
         else if (c == 27)          exp = V_RND;
         else if (c == 28)          exp = V_WB;
         else                       exp = V_IDLE;
         exp_it = (c >= 2 && c <= 25) ? 5'(c - 2) : 5'd0;
         checks++;
         if (obs !== exp || bus_if.IterCnt !== exp_it) begin
            errors++;
            $display("FAIL div_c%0d: got %b iter=%0d want %b iter=%0d", c, obs, bus_if.IterCnt, exp, exp_it);
         end
      end
   endtask

   task automatic test_flush;
      logic [8:0] exp;
      bus_if.FPUStart = 1'b1;
      bus_if.FPUOp    = 2'b10;
      for (int c = 0; c <= 7; c++) begin
         if (c > 0) tick();
         if (c == 1) bus_if.FPUStart = 1'b0;
         bus_if.Flush = (c == 3);
         @(negedge clk);
         if (c == 3) begin
            checks++;
            if ({obs[8], obs[1:0]} !== 3'b100) begin
               errors++;
               $display("FAIL flush_norm: got busy/fpuw/done=%b want 100", {obs[8], obs[1:0]});
            end
         end else begin
            case (c)
               1:       exp = V_UNP;
               2:       exp = V_EXE;
               default: exp = V_IDLE;
            endcase
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL flush_c%0d: got %b want %b", c, obs, exp);
            end
         end
      end
   endtask

   task automatic test_flush_idle;
      logic [8:0] exp;
      bus_if.FPUStart = 1'b1;
      bus_if.FPUOp    = 2'b10;
      bus_if.Flush    = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         if (c > 0) tick();
         if (c == 1) bus_if.Flush = 1'b0;
         if (c == 2) bus_if.FPUStart = 1'b0;
         @(negedge clk);
         case (c)
            2:       exp = V_UNP;
            3:       exp = V_EXE;
            4:       exp = V_NRM;
            5:       exp = V_RND;
            6:       exp = V_WB;
            default: exp = V_IDLE;
         endcase
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL flush_idle_c%0d: got %b want %b", c, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic exp_w, exp_u;
      bus_if.FPUStart = 1'b1;
      bus_if.FPUOp    = 2'b01;
      for (int c = 0; c <= 21; c++) begin
         if (c > 0) tick();
         if (c == 21) bus_if.FPUStart = 1'b0;
         @(negedge clk);
         exp_w = (c == 6) || (c == 13) || (c == 20);
         exp_u = (c == 1) || (c == 8) || (c == 15);
         checks++;
         if (bus_if.FPUW !== exp_w || bus_if.Done !== exp_w || bus_if.UnpackEn !== exp_u) begin
            errors++;
            $display("FAIL b2b_c%0d: got fpuw=%b done=%b unp=%b want %b %b %b",
                     c, bus_if.FPUW, bus_if.Done, bus_if.UnpackEn, exp_w, exp_w, exp_u);
         end
      end
      checks++;
      if (bus_if.OpQ !== 2'b01) begin
         errors++;
         $display("FAIL b2b_opq: got %b want 01", bus_if.OpQ);
      end
   endtask

   task automatic test_reset_mid_div;
      logic [8:0] exp;
      bus_if.FPUStart = 1'b1;
      bus_if.FPUOp    = 2'b11;
      for (int c = 1; c <= 12; c++) begin
         tick();
         bus_if.FPUStart = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus_if.IterCnt !== 5'd10) begin
         errors++;
         $display("FAIL rst_div_iter: got %0d want 10", bus_if.IterCnt);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== V_IDLE || bus_if.IterCnt !== 5'd0 || bus_if.OpQ !== 2'b00) begin
         errors++;
         $display("FAIL rst_async: got %b iter=%0d opq=%b want %b 0 00", obs, bus_if.IterCnt, bus_if.OpQ, V_IDLE);
      end
      tick();
      reset = 1'b0;
      bus_if.FPUStart = 1'b1;
      bus_if.FPUOp    = 2'b10;
      for (int c = 1; c <= 6; c++) begin
         tick();
         bus_if.FPUStart = 1'b0;
         @(negedge clk);
         case (c)
            1:       exp = V_UNP;
            2:       exp = V_EXE;
            3:       exp = V_NRM;
            4:       exp = V_RND;
            5:       exp = V_WB;
            default: exp = V_IDLE;
         endcase
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL rst_next_op_c%0d: got %b want %b", c, obs, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      tick();
      test_special();
      tick();
      test_add();
      tick();
      test_div();
      tick();
      test_flush();
      tick();
      test_flush_idle();
      tick();
      test_back_to_back();
      tick();
      test_reset_mid_div();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fpu_sequencer.md
FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 SHALL have parameter DIV_ITERS, default 24, legal range 2..31: number of EXEC cycles for divide.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high; forces IDLE immediately.
REQ-004 SHALL have port FPUStart, input, 1 bit: request from main FSM to start one FP operation.
REQ-005 SHALL have port FPUOp, input, 2 bits: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 SHALL have port Special, input, 1 bit: unpack stage flags NaN/Inf/zero operand; sampled in UNPACK only.
REQ-007 SHALL have port Flush, input, 1 bit: synchronous abort of the operation in flight.
REQ-008 SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have ports UnpackEn, AlignEn, ExecEn, NormEn, RoundEn, outputs, 1 bit each: stage register enables.
REQ-010 SHALL have port DivInit, output, 1 bit: high in the first EXEC cycle of a divide only.
REQ-011 SHALL have port IterCnt, output, 5 bits: divide iteration index, 0 in first EXEC cycle.
REQ-012 SHALL have port OpQ, output, 2 bits: FPUOp latched at accept.
REQ-013 SHALL have port ResSel, output, 1 bit: 1 = special-case result path, 0 = rounded result.
REQ-014 SHALL have ports FPUW and Done, outputs, 1 bit each: register-file write enable and completion pulse.

Function
REQ-015 SHALL implement states IDLE, UNPACK, ALIGN, EXEC, NORM, ROUND, WB.
REQ-016 SHALL accept a request only when in IDLE and FPUStart=1; accept cycle = cycle 0; OpQ <= FPUOp; next state UNPACK.
REQ-017 SHALL ignore FPUStart in all states other than IDLE; FPUOp changes after accept SHALL NOT affect OpQ.
REQ-018 SHALL transition from UNPACK: Special=1 -> WB with ResSel latched 1; else OpQ add/sub -> ALIGN; mul/div -> EXEC.
REQ-019 SHALL transition ALIGN -> EXEC; NORM -> ROUND; ROUND -> WB; WB -> IDLE.
REQ-020 SHALL remain in EXEC one cycle for add/sub/mul, DIV_ITERS cycles for div, then go to NORM.
REQ-021 SHALL increment IterCnt each div EXEC cycle, leave EXEC when IterCnt = DIV_ITERS-1, hold IterCnt at 0 outside div EXEC.
REQ-022 SHALL assert exactly one stage enable, matching the current state, in UNPACK..ROUND; none in IDLE or WB.
REQ-023 SHALL assert FPUW and Done only in WB, each for exactly one cycle, gated by Flush=0.
REQ-024 SHALL place WB at cycle 6 for add/sub, cycle 5 for mul, cycle 4+DIV_ITERS for div, cycle 2 for special-case.
REQ-025 SHALL, on Flush=1 in any non-IDLE state, go to IDLE on the next edge with FPUW=Done=0 in that cycle; Flush in IDLE has no effect and blocks accept that cycle.
REQ-026 SHALL clear ResSel to 0 on every accept; ResSel stays stable until next accept.
REQ-027 SHALL allow a new accept in the cycle after WB (back-to-back ops, one IDLE cycle minimum).
REQ-028 SHALL drive IDLE for any unreachable state encoding.

Reset
REQ-029 SHALL, on reset assertion, immediately force state IDLE, IterCnt=0, OpQ=00, ResSel=0, and all outputs 0, including mid-operation.
REQ-030 SHALL accept a request in the first rising edge after reset deassertion if FPUStart=1.

Verification
REQ-031 Add: FPUStart=1, FPUOp=00, Special=0 at cycle 0 -> enables Unpack,Align,Exec,Norm,Round in cycles 1-5; FPUW=Done=1 cycle 6 only; Busy cycles 1-6.
REQ-032 Div, DIV_ITERS=24: FPUOp=11 -> DivInit=1 cycle 2, IterCnt 0..23 cycles 2-25, NormEn cycle 26, FPUW cycle 28.
REQ-033 Special: FPUOp=10, Special=1 in cycle 1 -> WB cycle 2, ResSel=1, FPUW=1, no Exec/Norm/Round enables.
REQ-034 Flush: mul started cycle 0, Flush=1 cycle 3 (NORM) -> IDLE cycle 4, FPUW never asserted, Busy=0 cycle 4.
REQ-035 Reset mid-div at IterCnt=10 -> outputs 0 and Busy=0 without waiting for clk; next op after release runs full latency.
REQ-036 FPUStart held high continuously with FPUOp=01 -> ops accepted cycles 0,7,14; FPUW at cycles 6,13,20.
